// File: rtl/foc_pkg.sv
// Shared types for the FOC sample initiator: FSM states, config FIFO entry, period floor.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package foc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    WAIT_ACCEPT,
    WAIT_DONE
  } state_t;

  // Shortest loop period; anything smaller would tick every cycle or never.
  localparam int MIN_PERIOD = 2;

  // Config entry field width; matches the default D_WIDTH of the initiator.
  localparam int CFG_FIELD_W = 16;

  typedef struct packed {
    logic                   sel;   // 0 = D-axis PID, 1 = Q-axis PID
    logic [CFG_FIELD_W-1:0] addr;
    logic [CFG_FIELD_W-1:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/foc_sample_initiator_cfg_fifo.sv
// Synchronous FIFO holding PID register writes until the core is idle.
// Latency: a pushed entry is visible on dout the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered-pointer derived.
module cfg_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset flushes the contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/foc_sample_initiator.sv
// Periodic sample launcher for the FOC core plus PID gain writer gated on core idle.
// Latency: tick to valid_out 1 cycle; cfg push edge to pid_*_wen 1 cycle when idle.
// Backpressure: ticks while busy/not ready are dropped and counted; cfg_ready drops when the FIFO is full.
module foc_sample_initiator
  import foc_pkg::*;
#(
  parameter int D_WIDTH   = 16,
  parameter int CFG_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] period_cycles,
  input  logic [D_WIDTH-1:0] angle_in,
  input  logic [D_WIDTH-1:0] currA_in,
  input  logic [D_WIDTH-1:0] currB_in,
  input  logic [D_WIDTH-1:0] currC_in,
  input  logic [D_WIDTH-1:0] currT_in,
  input  logic [D_WIDTH-1:0] periodTop_in,
  output logic [D_WIDTH-1:0] angle_out,
  output logic [D_WIDTH-1:0] currA_out,
  output logic [D_WIDTH-1:0] currB_out,
  output logic [D_WIDTH-1:0] currC_out,
  output logic [D_WIDTH-1:0] currT_out,
  output logic [D_WIDTH-1:0] periodTop_out,
  output logic               valid_out,
  input  logic               core_ready,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_sel,
  input  logic [D_WIDTH-1:0] cfg_addr,
  input  logic [D_WIDTH-1:0] cfg_data,
  output logic               pid_d_wen,
  output logic               pid_q_wen,
  output logic [D_WIDTH-1:0] pid_d_addr,
  output logic [D_WIDTH-1:0] pid_q_addr,
  output logic [D_WIDTH-1:0] pid_d_data,
  output logic [D_WIDTH-1:0] pid_q_data,
  output logic               busy,
  output logic [15:0]        overrun_cnt,
  output logic               timeout_err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [D_WIDTH-1:0] P_MIN     = D_WIDTH'(MIN_PERIOD);
  localparam logic [WW-1:0]      WAIT_LAST = WW'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [D_WIDTH-1:0] period_eff;
  logic [D_WIDTH-1:0] period_last;
  logic [D_WIDTH-1:0] period_cnt;
  logic               tick;
  logic [WW-1:0]      wait_cnt;
  logic               wait_at_limit;
  logic               start;
  logic               clr_wait;
  logic               timeout_hit;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  cfg_entry_t         cfg_in;
  cfg_entry_t         fifo_dout;

  assign period_eff    = (period_cycles < P_MIN) ? P_MIN : period_cycles;
  assign period_last   = period_eff - D_WIDTH'(1);
  // >= keeps the loop ticking if the period shrinks below the running count.
  assign tick          = enable && (period_cnt >= period_last);
  assign wait_at_limit = (wait_cnt == WAIT_LAST);
  assign valid_out     = (state == SAMPLE);
  assign busy          = (state != IDLE);
  assign cfg_ready     = !fifo_full;
  // Gains only change between iterations; a sample start wins over a write.
  assign pop           = (state == IDLE) && core_ready && !tick && !fifo_empty;
  assign cfg_in        = '{sel: cfg_sel, addr: cfg_addr, data: cfg_data};

  cfg_fifo #(
    .WIDTH ($bits(cfg_entry_t)),
    .DEPTH (CFG_DEPTH)
  ) u_cfg_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cfg_valid),
    .din   (cfg_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Loop period counter: 0..P-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset || !enable || tick) period_cnt <= '0;
    else                          period_cnt <= period_cnt + D_WIDTH'(1);
  end

  // Handshake sequencing; a ready transition takes precedence over the timeout.
  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    clr_wait    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (tick && core_ready) begin
          state_nxt = SAMPLE;
          start     = 1'b1;
        end
      end
      SAMPLE: begin
        state_nxt = WAIT_ACCEPT;
        clr_wait  = 1'b1;
      end
      WAIT_ACCEPT: begin
        if (!core_ready) begin
          state_nxt = WAIT_DONE;
          clr_wait  = 1'b1;
        end else if (wait_at_limit) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (core_ready) begin
          state_nxt = IDLE;
        end else if (wait_at_limit) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, wait counter, overrun and timeout bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      overrun_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr_wait) wait_cnt <= '0;
      else if (state == WAIT_ACCEPT || state == WAIT_DONE) wait_cnt <= wait_cnt + WW'(1);
      if (tick && !start && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  // Sample snapshot, held stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      angle_out     <= '0;
      currA_out     <= '0;
      currB_out     <= '0;
      currC_out     <= '0;
      currT_out     <= '0;
      periodTop_out <= '0;
    end else if (start) begin
      angle_out     <= angle_in;
      currA_out     <= currA_in;
      currB_out     <= currB_in;
      currC_out     <= currC_in;
      currT_out     <= currT_in;
      periodTop_out <= periodTop_in;
    end
  end

  // PID write port: one-cycle enable on the selected axis, addr/data held between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pid_d_wen  <= 1'b0;
      pid_q_wen  <= 1'b0;
      pid_d_addr <= '0;
      pid_d_data <= '0;
      pid_q_addr <= '0;
      pid_q_data <= '0;
    end else begin
      pid_d_wen <= pop && !fifo_dout.sel;
      pid_q_wen <= pop && fifo_dout.sel;
      if (pop && !fifo_dout.sel) begin
        pid_d_addr <= fifo_dout.addr;
        pid_d_data <= fifo_dout.data;
      end
      if (pop && fifo_dout.sel) begin
        pid_q_addr <= fifo_dout.addr;
        pid_q_data <= fifo_dout.data;
      end
    end
  end

endmodule

// File: tb/tb_foc_sample_initiator.sv
// Directed bench for foc_sample_initiator with a small behavioural FOC core.
// Inputs driven and outputs sampled 1ns after the rising edge; core model acts on falling edges.
// Cycle indices in each test count from the cycle enable is first asserted (cycle 0).
module tb_foc_sample_initiator;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] period_cycles;
  logic [15:0] angle_in, currA_in, currB_in, currC_in, currT_in, periodTop_in;
  logic [15:0] angle_out, currA_out, currB_out, currC_out, currT_out, periodTop_out;
  logic        valid_out;
  logic        core_ready;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_sel;
  logic [15:0] cfg_addr, cfg_data;
  logic        pid_d_wen, pid_q_wen;
  logic [15:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;
  logic        busy;
  logic [15:0] overrun_cnt;
  logic        timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Core model controls
  bit core_auto    = 1'b1;
  int core_low_len = 4;
  bit core_idle    = 1'b1;

  foc_sample_initiator #(.D_WIDTH(16), .CFG_DEPTH(4), .TIMEOUT(1024)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .period_cycles (period_cycles),
    .angle_in      (angle_in),
    .currA_in      (currA_in),
    .currB_in      (currB_in),
    .currC_in      (currC_in),
    .currT_in      (currT_in),
    .periodTop_in  (periodTop_in),
    .angle_out     (angle_out),
    .currA_out     (currA_out),
    .currB_out     (currB_out),
    .currC_out     (currC_out),
    .currT_out     (currT_out),
    .periodTop_out (periodTop_out),
    .valid_out     (valid_out),
    .core_ready    (core_ready),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_sel       (cfg_sel),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .pid_d_wen     (pid_d_wen),
    .pid_q_wen     (pid_q_wen),
    .pid_d_addr    (pid_d_addr),
    .pid_q_addr    (pid_q_addr),
    .pid_d_data    (pid_d_data),
    .pid_q_data    (pid_q_data),
    .busy          (busy),
    .overrun_cnt   (overrun_cnt),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: ready drops the cycle after valid, returns core_low_len cycles later.
  initial begin
    core_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (core_auto && valid_out === 1'b1) begin
        core_idle = 1'b0;
        @(negedge clk);
        core_ready = 1'b0;
        repeat (core_low_len) @(negedge clk);
        core_ready = 1'b1;
        core_idle  = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    int n;
    reset     = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    core_auto = 1'b1;
    step();
    step();
    n = 0;
    while (!core_idle && n < 100) begin
      step();
      n++;
    end
    n_chk++;
    if (!core_idle) begin
      n_fail++;
      $display("FAIL reset_settle: core model busy=%0d required idle", !core_idle);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int n_busy;
    apply_reset();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", valid_out); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got %b exp 1", cfg_ready); end
    n_chk++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_overrun: got %0d exp 0", overrun_cnt); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b exp 0", timeout_err); end
    n_chk++; if ({pid_d_wen, pid_q_wen} !== 2'b00) begin n_fail++; $display("FAIL rst_wen: got %b exp 00", {pid_d_wen, pid_q_wen}); end
    n_chk++; if ({angle_out, currA_out, periodTop_out} !== 48'd0) begin n_fail++; $display("FAIL rst_outs: got %h exp 0", {angle_out, currA_out, periodTop_out}); end
    n_chk++; if ({pid_d_addr, pid_q_data} !== 32'd0) begin n_fail++; $display("FAIL rst_pid_regs: got %h exp 0", {pid_d_addr, pid_q_data}); end
    // With enable low no tick may ever fire
    period_cycles = 16'd2;
    n_busy = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (busy) n_busy++;
    end
    n_chk++; if (n_busy != 0) begin n_fail++; $display("FAIL disabled_busy: got %0d busy cycles exp 0", n_busy); end
  endtask

  task automatic test_period();
    int first_v, n_v, n_busy;
    apply_reset();
    core_low_len  = 4;
    period_cycles = 16'd10;
    angle_in = 16'h1234; currA_in = 16'hFF00; currB_in = 16'h0100;
    currC_in = 16'h7FFF; currT_in = 16'h8001; periodTop_in = 16'h0FA0;
    enable = 1'b1;
    first_v = -1; n_v = 0; n_busy = 0;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (valid_out) begin
        n_v++;
        if (first_v < 0) first_v = i;
      end
      if (busy) n_busy++;
      if (i == 10) begin
        n_chk++; if ({angle_out, currA_out, currB_out} !== 48'h1234_FF00_0100) begin n_fail++; $display("FAIL period_snap_abc: got %h exp 1234ff000100", {angle_out, currA_out, currB_out}); end
        n_chk++; if ({currC_out, currT_out, periodTop_out} !== 48'h7FFF_8001_0FA0) begin n_fail++; $display("FAIL period_snap_ctp: got %h exp 7fff80010fa0", {currC_out, currT_out, periodTop_out}); end
      end
      if (i == 20 || i == 30) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL period_valid_c%0d: got %b exp 1", i, valid_out); end
      end
    end
    n_chk++; if (first_v != 10) begin n_fail++; $display("FAIL period_first_valid: got cycle %0d exp 10", first_v); end
    n_chk++; if (n_v != 3) begin n_fail++; $display("FAIL period_valid_count: got %0d exp 3", n_v); end
    n_chk++; if (n_busy != 18) begin n_fail++; $display("FAIL period_busy_cycles: got %0d exp 18", n_busy); end
    n_chk++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL period_overrun: got %0d exp 0", overrun_cnt); end
  endtask

  task automatic test_min_period();
    apply_reset();
    core_low_len  = 4;
    period_cycles = 16'd0;
    enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 2 || i == 10) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL minper_valid_c%0d: got %b exp 1", i, valid_out); end
      end
      if (i == 4) begin
        n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL minper_no_valid_c4: got %b exp 0", valid_out); end
      end
    end
    n_chk++; if (overrun_cnt !== 16'd3) begin n_fail++; $display("FAIL minper_overrun: got %0d exp 3", overrun_cnt); end
  endtask

  task automatic test_overrun();
    apply_reset();
    core_low_len  = 25;
    period_cycles = 16'd10;
    angle_in = 16'hAAAA; currA_in = 16'h0011; currB_in = 16'h0022;
    currC_in = 16'h0033; currT_in = 16'hFFF0; periodTop_in = 16'h0200;
    enable = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i == 11) begin
        angle_in = 16'h5555; currT_in = 16'h0007;
      end
      if (i >= 11 && i <= 36) begin
        n_chk++; if ({angle_out, currT_out} !== 32'hAAAA_FFF0) begin n_fail++; $display("FAIL ovr_hold_c%0d: got %h exp aaaafff0", i, {angle_out, currT_out}); end
      end
      if (i == 38) begin
        n_chk++; if (overrun_cnt !== 16'd2) begin n_fail++; $display("FAIL ovr_cnt_loop1: got %0d exp 2", overrun_cnt); end
      end
      if (i == 40) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_c40: got %b exp 1", valid_out); end
        n_chk++; if ({angle_out, currT_out} !== 32'h5555_0007) begin n_fail++; $display("FAIL ovr_new_snap: got %h exp 55550007", {angle_out, currT_out}); end
      end
      if (i == 68) begin
        n_chk++; if (overrun_cnt !== 16'd4) begin n_fail++; $display("FAIL ovr_cnt_loop2: got %0d exp 4", overrun_cnt); end
      end
      if (i == 70) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_c70: got %b exp 1", valid_out); end
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    core_auto     = 1'b0;
    core_low_len  = 4;
    period_cycles = 16'd10;
    enable = 1'b1;
    for (int i = 1; i <= 1046; i++) begin
      step();
      if (i == 10) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL to_valid_c10: got %b exp 1", valid_out); end
      end
      if (i == 1034) begin
        n_chk++; if ({timeout_err, busy} !== 2'b01) begin n_fail++; $display("FAIL to_before: got err,busy=%b exp 01", {timeout_err, busy}); end
      end
      if (i == 1035) begin
        n_chk++; if ({timeout_err, busy} !== 2'b10) begin n_fail++; $display("FAIL to_after: got err,busy=%b exp 10", {timeout_err, busy}); end
        n_chk++; if (overrun_cnt !== 16'd102) begin n_fail++; $display("FAIL to_overrun: got %0d exp 102", overrun_cnt); end
        core_auto = 1'b1;
      end
      if (i == 1040) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL to_resume_valid: got %b exp 1", valid_out); end
      end
      if (i == 1046) begin
        n_chk++; if ({timeout_err, busy} !== 2'b10) begin n_fail++; $display("FAIL to_sticky: got err,busy=%b exp 10", {timeout_err, busy}); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, j;
    logic [1:0] exp_wen;
    apply_reset();
    core_low_len  = 4;
    period_cycles = 16'd20;
    enable = 1'b1;
    k = 0;
    for (int i = 1; i <= 33; i++) begin
      step();
      j = i - 27;
      exp_wen = (i >= 27 && i <= 31) ? ((j % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
      n_chk++; if ({pid_d_wen, pid_q_wen} !== exp_wen) begin n_fail++; $display("FAIL b2b_wen_c%0d: got %b exp %b", i, {pid_d_wen, pid_q_wen}, exp_wen); end
      if (exp_wen == 2'b10) begin
        n_chk++; if ({pid_d_addr, pid_d_data} !== {16'(j), 16'(16'hA0 + j)}) begin n_fail++; $display("FAIL b2b_d_entry%0d: got %h exp %h", j, {pid_d_addr, pid_d_data}, {16'(j), 16'(16'hA0 + j)}); end
      end
      if (exp_wen == 2'b01) begin
        n_chk++; if ({pid_q_addr, pid_q_data} !== {16'(j), 16'(16'hA0 + j)}) begin n_fail++; $display("FAIL b2b_q_entry%0d: got %h exp %h", j, {pid_q_addr, pid_q_data}, {16'(j), 16'(16'hA0 + j)}); end
      end
      if (i == 20) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b exp 1", valid_out); end
      end
      if (i == 25 || i == 26) begin
        n_chk++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_c%0d: cfg_ready got %b exp 0 (pushed %0d)", i, cfg_ready, k); end
      end
      if (i >= 21 && k < 5) begin
        cfg_valid = 1'b1;
        cfg_sel   = k[0];
        cfg_addr  = 16'(k);
        cfg_data  = 16'(16'hA0 + k);
      end else begin
        cfg_valid = 1'b0;
      end
      if (cfg_valid && cfg_ready) k++;
    end
    cfg_valid = 1'b0;
    n_chk++; if (k != 5) begin n_fail++; $display("FAIL b2b_accepted: got %0d exp 5", k); end
  endtask

  task automatic test_tick_priority();
    logic [1:0] exp_wen;
    apply_reset();
    core_low_len  = 4;
    period_cycles = 16'd10;
    enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_wen = (i == 17) ? 2'b01 : (i == 19) ? 2'b10 : 2'b00;
      n_chk++; if ({pid_d_wen, pid_q_wen} !== exp_wen) begin n_fail++; $display("FAIL prio_wen_c%0d: got %b exp %b", i, {pid_d_wen, pid_q_wen}, exp_wen); end
      if (i == 10) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL prio_valid: got %b exp 1", valid_out); end
      end
      if (i == 17) begin
        n_chk++; if ({pid_q_addr, pid_q_data} !== 32'h0033_5A5A) begin n_fail++; $display("FAIL prio_q_entry: got %h exp 00335a5a", {pid_q_addr, pid_q_data}); end
      end
      if (i == 19) begin
        n_chk++; if ({pid_d_addr, pid_d_data} !== 32'h0044_1234) begin n_fail++; $display("FAIL prio_d_entry: got %h exp 00441234", {pid_d_addr, pid_d_data}); end
      end
      if (i == 8) begin
        cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_addr = 16'h0033; cfg_data = 16'h5A5A;
      end else if (i == 17) begin
        cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_addr = 16'h0044; cfg_data = 16'h1234;
      end else begin
        cfg_valid = 1'b0;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    core_low_len  = 25;
    period_cycles = 16'd10;
    angle_in = 16'hBEEF;
    enable = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (i >= 12 && i <= 14) begin
        cfg_valid = 1'b1; cfg_sel = i[0]; cfg_addr = 16'(i); cfg_data = 16'h00C0;
      end else begin
        cfg_valid = 1'b0;
      end
      if (i == 20) begin
        n_chk++; if ({busy, overrun_cnt} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL rmid_pre: got busy,ovr=%h exp 10001", {busy, overrun_cnt}); end
        reset  = 1'b1;
        enable = 1'b0;
      end
      if (i == 21) begin
        reset = 1'b0;
        n_chk++; if ({busy, valid_out, cfg_ready} !== 3'b001) begin n_fail++; $display("FAIL rmid_ctl: got busy,valid,cfg_ready=%b exp 001", {busy, valid_out, cfg_ready}); end
        n_chk++; if ({overrun_cnt, angle_out, timeout_err} !== 33'd0) begin n_fail++; $display("FAIL rmid_outs: got %h exp 0", {overrun_cnt, angle_out, timeout_err}); end
      end
      if (i >= 21) begin
        n_chk++; if ({pid_d_wen, pid_q_wen, busy} !== 3'b000) begin n_fail++; $display("FAIL rmid_quiet_c%0d: got wen_d,wen_q,busy=%b exp 000", i, {pid_d_wen, pid_q_wen, busy}); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; period_cycles = '0;
    angle_in = '0; currA_in = '0; currB_in = '0; currC_in = '0; currT_in = '0; periodTop_in = '0;
    cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    test_reset();
    test_period();
    test_min_period();
    test_overrun();
    test_timeout();
    test_back_to_back();
    test_tick_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
